decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 205 ++++++++++++++++++++
 tb/tb_decode_stage.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
`timescale 1ns/1ps
// Decode stage: turns a fetched instruction into an execute payload and
// holds it in a two-entry (head + skid) buffer so fetch can keep streaming
// one instruction per cycle while execute applies back-pressure.
module decode_stage (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_instValid,
   output logic        o_instReady,
   input  logic [31:0] i_inst,
   input  logic [31:0] i_pc,
   input  logic        i_flush,
   output logic [4:0]  o_rs1Addr,
   input  logic [31:0] i_rs1Data,
   output logic        o_exValid,
   input  logic        i_exReady,
   output logic [31:0] o_exPc,
   output logic [31:0] o_exRs1Data,
   output logic [31:0] o_exImm,
   output logic [4:0]  o_exRdAddr,
   output logic [6:0]  o_exOpcode,
   output logic [2:0]  o_exFunct3,
   output logic        o_exIllegal
);

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } bufState_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rs1Data;
      logic [31:0] imm;
      logic [4:0]  rdAddr;
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic        illegal;
   } payload_t;

   bufState_t state;
   bufState_t nextState;
   payload_t  headReg;
   payload_t  skidReg;
   payload_t  newEntry;
   logic [31:0] decImm;
   logic        decIllegal;
   logic        accept;
   logic        dequeue;
   logic        loadHeadNew;
   logic        loadHeadSkid;
   logic        loadSkid;

   // The register file is read combinationally, so the rs1 field is exposed
   // straight from the offered instruction and its data is captured with it.
   assign o_rs1Addr = i_inst[19:15];

   // Ready is held low during reset so fetch never sees a handshake that the
   // buffer would immediately throw away.
   assign o_instReady = !i_reset && (state != TWO);
   assign o_exValid   = (state != EMPTY);

   // A flush wins over an offer in the same cycle; a dequeue in a flush cycle
   // is still a real handshake from execute's point of view.
   assign accept  = i_instValid && o_instReady && !i_flush;
   assign dequeue = o_exValid && i_exReady;

   // Immediate reconstruction and legality check, keyed purely on the opcode.
   // Anything not in the supported set decodes with a zero immediate and is
   // flagged illegal, but still travels down the pipe so execute can trap.
   always_comb begin
      decImm     = '0;
      decIllegal = 1'b0;
      case (i_inst[6:0])
         OP_IMM, OP_LOAD, OP_JALR: begin
            decImm = {{20{i_inst[31]}}, i_inst[31:20]};
         end
         OP_STORE: begin
            decImm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
         end
         OP_BRANCH: begin
            decImm = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                      i_inst[30:25], i_inst[11:8], 1'b0};
         end
         OP_LUI, OP_AUIPC: begin
            decImm = {i_inst[31:12], 12'h000};
         end
         OP_JAL: begin
            decImm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12],
                      i_inst[20], i_inst[30:21], 1'b0};
         end
         OP_REG: begin
            decImm = '0;
         end
         default: begin
            decIllegal = 1'b1;
         end
      endcase
      if (i_inst[1:0] != 2'b11) begin
         decIllegal = 1'b1;
      end
   end

   // Bundle the decoded fields of the offered instruction into one payload
   // word so the head and skid registers can be loaded as a unit.
   always_comb begin
      newEntry         = '0;
      newEntry.pc      = i_pc;
      newEntry.rs1Data = i_rs1Data;
      newEntry.imm     = decImm;
      newEntry.rdAddr  = i_inst[11:7];
      newEntry.opcode  = i_inst[6:0];
      newEntry.funct3  = i_inst[14:12];
      newEntry.illegal = decIllegal;
   end

   // Buffer occupancy register; reset drops any held instruction at once.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state <= EMPTY;
      end else begin
         state <= nextState;
      end
   end

   // Occupancy transitions and the matching load strobes. The head always
   // holds the oldest entry; the skid only fills when execute stalls while
   // the head is occupied, and drains back into the head on the next dequeue.
   always_comb begin
      nextState    = state;
      loadHeadNew  = 1'b0;
      loadHeadSkid = 1'b0;
      loadSkid     = 1'b0;
      if (i_flush) begin
         nextState = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  nextState   = ONE;
                  loadHeadNew = 1'b1;
               end
            end
            ONE: begin
               if (accept && dequeue) begin
                  nextState   = ONE;
                  loadHeadNew = 1'b1;
               end else if (accept) begin
                  nextState = TWO;
                  loadSkid  = 1'b1;
               end else if (dequeue) begin
                  nextState = EMPTY;
               end
            end
            TWO: begin
               if (dequeue) begin
                  nextState    = ONE;
                  loadHeadSkid = 1'b1;
               end
            end
            default: begin
               nextState = EMPTY;
            end
         endcase
      end
   end

   // Payload storage. The head only changes on a load strobe, which keeps the
   // execute outputs frozen for as long as execute is stalling.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         headReg <= '0;
         skidReg <= '0;
      end else begin
         if (loadHeadNew) begin
            headReg <= newEntry;
         end else if (loadHeadSkid) begin
            headReg <= skidReg;
         end
         if (loadSkid) begin
            skidReg <= newEntry;
         end
      end
   end

   assign o_exPc      = headReg.pc;
   assign o_exRs1Data = headReg.rs1Data;
   assign o_exImm     = headReg.imm;
   assign o_exRdAddr  = headReg.rdAddr;
   assign o_exOpcode  = headReg.opcode;
   assign o_exFunct3  = headReg.funct3;
   assign o_exIllegal = headReg.illegal;

endmodule

// File: tb/tb_decode_stage.sv
`timescale 1ns/1ps
// Self-checking bench for decode_stage: directed scenarios followed by a
// randomized stream, all checked against a queue-based reference model.
module tb_decode_stage;

   logic        i_clk;
   logic        i_reset;
   logic        i_instValid;
   logic        o_instReady;
   logic [31:0] i_inst;
   logic [31:0] i_pc;
   logic        i_flush;
   logic [4:0]  o_rs1Addr;
   logic [31:0] i_rs1Data;
   logic        o_exValid;
   logic        i_exReady;
   logic [31:0] o_exPc;
   logic [31:0] o_exRs1Data;
   logic [31:0] o_exImm;
   logic [4:0]  o_exRdAddr;
   logic [6:0]  o_exOpcode;
   logic [2:0]  o_exFunct3;
   logic        o_exIllegal;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] rs1;
      logic [31:0] imm;
      logic [31:0] rd;
      logic [31:0] opcode;
      logic [31:0] funct3;
      logic [31:0] illegal;
   } expEntry_t;

   expEntry_t modelQ[$];
   int checks = 0;
   int errors = 0;

   logic [6:0] legalOps [9] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63,
                                7'h37, 7'h17, 7'h6F, 7'h33};

   decode_stage dut (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_instValid (i_instValid),
      .o_instReady (o_instReady),
      .i_inst      (i_inst),
      .i_pc        (i_pc),
      .i_flush     (i_flush),
      .o_rs1Addr   (o_rs1Addr),
      .i_rs1Data   (i_rs1Data),
      .o_exValid   (o_exValid),
      .i_exReady   (i_exReady),
      .o_exPc      (o_exPc),
      .o_exRs1Data (o_exRs1Data),
      .o_exImm     (o_exImm),
      .o_exRdAddr  (o_exRdAddr),
      .o_exOpcode  (o_exOpcode),
      .o_exFunct3  (o_exFunct3),
      .o_exIllegal (o_exIllegal)
   );

   // Free-running 10ns clock.
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // Guard against a stalled run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Immediate from the instruction encoding using arithmetic shifts and masks.
   function automatic logic [31:0] refImm(input logic [31:0] inst);
      logic signed [31:0] s;
      logic signed [31:0] top;
      logic [31:0] op;
      s  = inst;
      op = inst & 32'h7F;
      if (op == 32'h13 || op == 32'h03 || op == 32'h67) begin
         top = s >>> 20;
         return top;
      end else if (op == 32'h23) begin
         top = s >>> 25;
         return (top << 5) | ((inst >> 7) & 32'h1F);
      end else if (op == 32'h63) begin
         top = s >>> 31;
         return (top << 12) | (((inst >> 7) & 32'h1) << 11)
              | (((inst >> 25) & 32'h3F) << 5) | (((inst >> 8) & 32'hF) << 1);
      end else if (op == 32'h37 || op == 32'h17) begin
         return inst & 32'hFFFFF000;
      end else if (op == 32'h6F) begin
         top = s >>> 31;
         return (top << 20) | (((inst >> 12) & 32'hFF) << 12)
              | (((inst >> 20) & 32'h1) << 11) | (((inst >> 21) & 32'h3FF) << 1);
      end
      return 32'h0;
   endfunction

   function automatic logic [31:0] refIllegal(input logic [31:0] inst);
      logic [31:0] op;
      logic listed;
      op = inst & 32'h7F;
      listed = 1'b0;
      for (int k = 0; k < 9; k++) begin
         if (op == 32'(legalOps[k])) listed = 1'b1;
      end
      return ((inst & 32'h3) != 32'h3 || !listed) ? 32'h1 : 32'h0;
   endfunction

   function automatic expEntry_t makeEntry(input logic [31:0] inst,
                                           input logic [31:0] pc,
                                           input logic [31:0] rs1);
      expEntry_t e;
      e.pc      = pc;
      e.rs1     = rs1;
      e.imm     = refImm(inst);
      e.rd      = (inst >> 7) & 32'h1F;
      e.opcode  = inst & 32'h7F;
      e.funct3  = (inst >> 12) & 32'h7;
      e.illegal = refIllegal(inst);
      return e;
   endfunction

   function automatic logic [31:0] randInst();
      logic [31:0] r;
      int k;
      r = $urandom;
      k = $urandom_range(0, 11);
      if (k < 9) r = (r & 32'hFFFFFF80) | 32'(legalOps[k]);
      return r;
   endfunction

   task automatic checkEq(input string tag, input logic [31:0] observed,
                          input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Compare the DUT against the model's current occupancy and head entry.
   task automatic checkOutput();
      checkEq("rs1Addr", 32'(o_rs1Addr), (i_inst >> 15) & 32'h1F);
      checkEq("instReady", 32'(o_instReady), 32'(modelQ.size() < 2));
      checkEq("exValid", 32'(o_exValid), 32'(modelQ.size() != 0));
      if (modelQ.size() != 0) begin
         checkEq("exPc", o_exPc, modelQ[0].pc);
         checkEq("exRs1Data", o_exRs1Data, modelQ[0].rs1);
         checkEq("exImm", o_exImm, modelQ[0].imm);
         checkEq("exRdAddr", 32'(o_exRdAddr), modelQ[0].rd);
         checkEq("exOpcode", 32'(o_exOpcode), modelQ[0].opcode);
         checkEq("exFunct3", 32'(o_exFunct3), modelQ[0].funct3);
         checkEq("exIllegal", 32'(o_exIllegal), modelQ[0].illegal);
      end
   endtask

   task automatic checkResetState(input string tag);
      checkEq({tag, ".exValid"}, 32'(o_exValid), 32'h0);
      checkEq({tag, ".instReady"}, 32'(o_instReady), 32'h0);
      checkEq({tag, ".exPc"}, o_exPc, 32'h0);
      checkEq({tag, ".exRs1Data"}, o_exRs1Data, 32'h0);
      checkEq({tag, ".exImm"}, o_exImm, 32'h0);
      checkEq({tag, ".exRdAddr"}, 32'(o_exRdAddr), 32'h0);
      checkEq({tag, ".exOpcode"}, 32'(o_exOpcode), 32'h0);
      checkEq({tag, ".exFunct3"}, 32'(o_exFunct3), 32'h0);
      checkEq({tag, ".exIllegal"}, 32'(o_exIllegal), 32'h0);
   endtask

   // Drive one cycle of inputs, check before the edge, then advance the model.
   task automatic applyStimulus(input logic valid, input logic [31:0] inst,
                                input logic [31:0] pc, input logic [31:0] rs1,
                                input logic exReady, input logic flush);
      logic acc;
      logic deq;
      i_instValid = valid;
      i_inst      = inst;
      i_pc        = pc;
      i_rs1Data   = rs1;
      i_exReady   = exReady;
      i_flush     = flush;
      #1;
      checkOutput();
      acc = valid && (modelQ.size() < 2) && !flush;
      deq = (modelQ.size() != 0) && exReady;
      @(posedge i_clk);
      if (flush) begin
         modelQ.delete();
      end else begin
         if (deq) void'(modelQ.pop_front());
         if (acc) modelQ.push_back(makeEntry(inst, pc, rs1));
      end
      #1;
   endtask

   initial begin
      i_reset     = 1'b1;
      i_instValid = 1'b0;
      i_inst      = '0;
      i_pc        = '0;
      i_rs1Data   = '0;
      i_exReady   = 1'b0;
      i_flush     = 1'b0;

      repeat (2) @(posedge i_clk);
      #1;
      checkResetState("por");
      #3 i_reset = 1'b0;

      $display("[TB] addi x1,x0,5");
      applyStimulus(1'b1, 32'h00500093, 32'h0, 32'h0, 1'b1, 1'b0);
      checkEq("s1.exValid", 32'(o_exValid), 32'h1);
      checkEq("s1.exImm", o_exImm, 32'h5);
      checkEq("s1.exRdAddr", 32'(o_exRdAddr), 32'h1);
      checkEq("s1.exIllegal", 32'(o_exIllegal), 32'h0);

      $display("[TB] addi x2,x2,-1");
      applyStimulus(1'b1, 32'hFFF10113, 32'h4, 32'h1234, 1'b1, 1'b0);
      checkEq("s2.exImm", o_exImm, 32'hFFFFFFFF);
      checkEq("s2.exRs1Data", o_exRs1Data, 32'h1234);
      checkEq("s2.exPc", o_exPc, 32'h4);
      applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

      $display("[TB] stall with three offers");
      applyStimulus(1'b1, 32'h00308193, 32'h10, 32'hA1, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h00410213, 32'h14, 32'hA2, 1'b0, 1'b0);
      checkEq("s3.instReadyTwo", 32'(o_instReady), 32'h0);
      checkEq("s3.headPc", o_exPc, 32'h10);
      applyStimulus(1'b1, 32'h00518293, 32'h18, 32'hA3, 1'b0, 1'b0);
      checkEq("s3.headStable", o_exPc, 32'h10);
      applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
      checkEq("s3.secondPc", o_exPc, 32'h14);
      applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
      checkEq("s3.drained", 32'(o_exValid), 32'h0);

      $display("[TB] back-to-back stream");
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, {12'(i), 5'd0, 3'b000, 5'(i + 1), 7'h13},
                       32'h100 + 32'(i * 4), $urandom, 1'b1, 1'b0);
         checkEq("s4.exValid", 32'(o_exValid), 32'h1);
         checkEq("s4.exPc", o_exPc, 32'h100 + 32'(i * 4));
      end
      applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
      checkEq("s4.drained", 32'(o_exValid), 32'h0);

      $display("[TB] flush from full");
      applyStimulus(1'b1, 32'h00100093, 32'h200, 32'h1, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h00200113, 32'h204, 32'h2, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h00300193, 32'h208, 32'h3, 1'b0, 1'b1);
      checkEq("s5.exValid", 32'(o_exValid), 32'h0);
      checkEq("s5.instReady", 32'(o_instReady), 32'h1);
      applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
      checkEq("s5.notIssued", 32'(o_exValid), 32'h0);

      $display("[TB] illegal word then reset mid-stream");
      applyStimulus(1'b1, 32'h00000000, 32'h300, 32'h55, 1'b1, 1'b0);
      checkEq("s6.exValid", 32'(o_exValid), 32'h1);
      checkEq("s6.exIllegal", 32'(o_exIllegal), 32'h1);
      checkEq("s6.exImm", o_exImm, 32'h0);
      applyStimulus(1'b1, 32'h00C00513, 32'h304, 32'h66, 1'b0, 1'b0);
      i_instValid = 1'b0;
      #2 i_reset = 1'b1;
      #1;
      checkResetState("midReset");
      modelQ.delete();
      @(posedge i_clk);
      #3 i_reset = 1'b0;
      applyStimulus(1'b1, 32'h00100093, 32'h400, 32'h7, 1'b1, 1'b0);
      checkEq("s6.firstAfterReset", 32'(o_exValid), 32'h1);
      checkEq("s6.firstPc", o_exPc, 32'h400);

      $display("[TB] randomized stream");
      for (int i = 0; i < 300; i++) begin
         applyStimulus($urandom_range(0, 3) != 0, randInst(), $urandom, $urandom,
                       $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      end
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
      end
      checkOutput();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
